fetch_stage: RTL

//  Stage 1 of the five-stage pipeline: owns the PC, fetches 16-bit words from instruction memory
//  and fills the Fetch/Decode buffer that feeds the decode stage (opcode/src/dst fields).

---
 rtl/fetch_stage.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, reads instruction memory and fills the Fetch/Decode buffer.
// Handles boot/interrupt vector loads, two-word immediate assembly and interrupt injection.
module fetch_stage #(
  parameter int PC_W    = 32,
  parameter int ADDR_W  = 20,
  parameter int RST_VEC = 0,
  parameter int INT_VEC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       imem_data,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              pc_enable,
  input  logic              fd_enable,
  input  logic              flush,
  input  logic              jump_sel,
  input  logic [PC_W-1:0]   jump_target,
  input  logic              interrupt,
  output logic [15:0]       fd_inst,
  output logic [15:0]       fd_imm,
  output logic [PC_W-1:0]   fd_pc,
  output logic              fd_valid,
  output logic              fd_int
);

  typedef enum logic [1:0] {BOOT, RUN, IMM, INTV} state_t;

  typedef struct packed {
    logic [15:0]     inst;
    logic [15:0]     imm;
    logic [PC_W-1:0] pc;
    logic            valid;
    logic            intr;
  } fd_t;

  localparam logic [ADDR_W-1:0] RST_A = ADDR_W'(RST_VEC);
  localparam logic [ADDR_W-1:0] INT_A = ADDR_W'(INT_VEC);

  state_t          state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic            int_pend, int_pend_n, take_int;
  logic [15:0]     hold_inst, hold_inst_n;
  logic [PC_W-1:0] hold_pc, hold_pc_n;
  fd_t             fd_q, fd_w, fd_n;

  logic [PC_W-1:0] pc_inc, word_ext;
  logic            two_word;

  assign pc_inc   = pc + PC_W'(1);
  assign word_ext = PC_W'(imem_data);
  assign two_word = (imem_data[15:14] == 2'b11);

  always_comb begin
    case (state)
      BOOT:    imem_addr = RST_A;
      INTV:    imem_addr = INT_A;
      default: imem_addr = pc[ADDR_W-1:0];
    endcase
  end

  // fd_w is what the FSM would like to write; fd_enable/flush decide what lands.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    take_int    = 1'b0;
    hold_inst_n = hold_inst;
    hold_pc_n   = hold_pc;
    fd_w        = fd_q;
    case (state)
      BOOT: begin
        pc_n    = word_ext;
        state_n = RUN;
      end
      RUN: begin
        if (jump_sel) begin
          pc_n       = jump_target;
          fd_w.valid = 1'b0;
        end else if (pc_enable) begin
          if (int_pend) begin
            fd_w.intr  = 1'b1;
            fd_w.valid = 1'b0;
            fd_w.pc    = pc;
            take_int   = 1'b1;
            state_n    = INTV;
          end else if (two_word) begin
            hold_inst_n = imem_data;
            hold_pc_n   = pc;
            pc_n        = pc_inc;
            fd_w.valid  = 1'b0;
            state_n     = IMM;
          end else begin
            fd_w.inst  = imem_data;
            fd_w.imm   = 16'h0;
            fd_w.pc    = pc;
            fd_w.valid = 1'b1;
            pc_n       = pc_inc;
          end
        end
      end
      IMM: begin
        if (jump_sel) begin
          pc_n    = jump_target;
          state_n = RUN;
        end else if (pc_enable) begin
          fd_w.inst  = hold_inst;
          fd_w.imm   = imem_data;
          fd_w.pc    = hold_pc;
          fd_w.valid = 1'b1;
          pc_n       = pc_inc;
          state_n    = RUN;
        end
      end
      INTV: begin
        if (pc_enable) begin
          pc_n       = word_ext;
          fd_w.intr  = 1'b0;
          fd_w.valid = 1'b0;
          state_n    = RUN;
        end
      end
      default: state_n = BOOT;
    endcase

    if (flush) begin
      fd_n       = fd_q;
      fd_n.valid = 1'b0;
      fd_n.intr  = 1'b0;
      fd_n.inst  = 16'h0;
    end else if (fd_enable) begin
      fd_n = fd_w;
    end else begin
      fd_n = fd_q;
    end

    // A request arriving on the service edge re-arms the pending flag.
    int_pend_n = (int_pend & ~take_int) | interrupt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT;
      pc        <= '0;
      int_pend  <= 1'b0;
      hold_inst <= '0;
      hold_pc   <= '0;
      fd_q      <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      int_pend  <= int_pend_n;
      hold_inst <= hold_inst_n;
      hold_pc   <= hold_pc_n;
      fd_q      <= fd_n;
    end
  end

  assign fd_inst  = fd_q.inst;
  assign fd_imm   = fd_q.imm;
  assign fd_pc    = fd_q.pc;
  assign fd_valid = fd_q.valid;
  assign fd_int   = fd_q.intr;

endmodule
